// File: rtl/prog_sequencer_pkg.sv
// Shared opcode constants and control states for the program sequencer.
// Imported by prog_sequencer.
package prog_sequencer_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MOVO = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    IMM_FETCH,
    IMM_LOAD,
    WAIT_DONE,
    HALT
  } state_e;

  // Reserved opcodes stop the program just like OP_HALT.
  function automatic logic op_stops(input logic [2:0] op);
    return !(op inside {OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MOVO});
  endfunction

endpackage

// File: rtl/prog_sequencer.sv
// Fetches program words and hands them to the processor one at a time.
// Optional watchdog on the done handshake: define WATCHDOG_EN.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int WD_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [8:0]        mem_data,
  output logic [8:0]        din,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic [7:0]        instr_cnt,
  output logic              err
);

  if (WD_LIMIT < 1) begin : g_bad_wd_limit
    $error("WD_LIMIT must be at least 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [8:0]        ir_q, ir_d;
  logic [8:0]        imm_q, imm_d;
  logic [8:0]        din_q, din_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ir_mvi;

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  assign ir_mvi = (ir_q[8:6] == OP_MVI);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    imm_d      = imm_q;
    din_d      = din_q;
    run_d      = run_q;
    cnt_d      = cnt_q;
`ifdef WATCHDOG_EN
    wd_d       = wd_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          run_d   = 1'b0;
          state_d = FETCH;
`ifdef WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      FETCH: begin
        mem_addr_d = pc_q;
        state_d    = LOAD;
      end
      LOAD: begin
        ir_d = mem_data;
        if (op_stops(mem_data[8:6])) begin
          state_d = HALT;
        end else if (mem_data[8:6] == OP_MVI) begin
          mem_addr_d = pc_q + ADDR_W'(1);
          state_d    = IMM_FETCH;
        end else begin
          state_d = ISSUE;
        end
      end
      IMM_FETCH: state_d = IMM_LOAD;
      IMM_LOAD: begin
        imm_d   = mem_data;
        state_d = ISSUE;
      end
      ISSUE: begin
        din_d   = ir_q;
        run_d   = 1'b1;
        state_d = WAIT_DONE;
`ifdef WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      WAIT_DONE: begin
        din_d = ir_mvi ? imm_q : ir_q;
        if (done) begin
          run_d   = 1'b0;
          pc_d    = pc_q + (ir_mvi ? ADDR_W'(2) : ADDR_W'(1));
          state_d = FETCH;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
`ifdef WATCHDOG_EN
        else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
          err_d   = 1'b1;
          run_d   = 1'b0;
          state_d = HALT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d   = !(state_d inside {IDLE, HALT});
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      imm_q      <= '0;
      din_q      <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      imm_q      <= imm_d;
      din_q      <= din_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mem_addr  = mem_addr_q;
  assign din       = din_q;
  assign run       = run_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer with a 4-word program memory.
// Expectations follow WATCHDOG_EN when it is defined.
module tb_prog_sequencer;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rstn, start, done;
  logic [AW-1:0] mem_addr;
  logic [8:0]    mem_data, din;
  logic          run, busy, halted, err;
  logic [7:0]    instr_cnt;
  logic [8:0]    mem [4];

  typedef struct {
    logic [8:0] di;
    logic [8:0] dw;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   trig = 0;
  bit   ok;

  prog_sequencer #(.ADDR_W(AW), .WD_LIMIT(15)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .din(din), .run(run), .done(done),
    .busy(busy), .halted(halted),
    .instr_cnt(instr_cnt), .err(err)
  );

  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, x);
    end
  endtask

  task automatic push(input logic [8:0] di, input logic [8:0] dw,
                      input int lat);
    exp_t e;
    e.di = di; e.dw = dw; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic load4(input logic [8:0] a, input logic [8:0] b,
                       input logic [8:0] c, input logic [8:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1; trig = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_rst();
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", din, 0);
  endtask

  task automatic wait_run(output bit got);
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (run === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL run_timeout got=0 want=1");
    end
  endtask

  task automatic wait_halt();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (halted === 1'b1) begin got = 1'b1; break; end
    end
    chk("halt_reached", got, 1);
  endtask

  task automatic serve(input int n);
    bit got;
    for (int i = 0; i < n; i++) begin
      wait_run(got);
      if (!got) return;
      @(posedge clk);
      @(posedge clk); #1 done = 1'b1; trig = cyc;
      @(posedge clk); #1 done = 1'b0;
    end
  endtask

  // Monitor: pops one expectation per rising edge of run.
  initial begin
    exp_t e;
    bit   pend;
    logic rp;
    pend = 1'b0;
    rp   = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("din_wait", din, e.dw);
        pend = 1'b0;
      end else if (run === 1'b1 && rp !== 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_run din=%0h want=none", din);
        end else begin
          e = q.pop_front();
          chk("din_issue", din, e.di);
          chk("latency", cyc - trig, e.lat);
          pend = 1'b1;
        end
      end
      rp = run;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=stuck want=finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; done = 1'b0;
    load4(9'h008, 9'h1C0, 9'h000, 9'h000);
    do_reset();
    @(negedge clk);
    check_rst();

    // mv then halt
    push(9'h008, 9'h008, 4);
    pulse_start();
    @(negedge clk);
    chk("busy_fetch", busy, 1);
    serve(1);
    wait_halt();
    chk("t1_run", run, 0);
    chk("t1_cnt", instr_cnt, 1);
    chk("t1_pc", mem_addr, 1);
    chk("t1_busy", busy, 0);

    // mvi with immediate, restarted from HALT
    load4(9'h048, 9'h155, 9'h1C0, 9'h000);
    push(9'h048, 9'h155, 6);
    pulse_start();
    @(negedge clk);
    chk("t2_cnt_clr", instr_cnt, 0);
    chk("t2_halt_clr", halted, 0);
    serve(1);
    wait_halt();
    chk("t2_pc", mem_addr, 2);
    chk("t2_cnt", instr_cnt, 1);
    chk("t2_din", din, 9'h155);

    // pc wraps 3 -> 1; mvi at 3 takes its immediate from 0
    load4(9'h081, 9'h0C2, 9'h003, 9'h04B);
    push(9'h081, 9'h081, 4);
    push(9'h0C2, 9'h0C2, 4);
    push(9'h003, 9'h003, 4);
    push(9'h04B, 9'h081, 6);
    push(9'h0C2, 9'h0C2, 4);
    push(9'h003, 9'h003, 4);
    pulse_start();
    serve(6);
    @(negedge clk);
    chk("t3_halted", halted, 0);
    chk("t3_busy", busy, 1);
    chk("t3_cnt", instr_cnt, 6);
    do_reset();

    // reset while waiting for done
    load4(9'h008, 9'h1C0, 9'h000, 9'h000);
    push(9'h008, 9'h008, 4);
    pulse_start();
    wait_run(ok);
    @(negedge clk);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check_rst();
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_spur_busy", busy, 0);
    chk("t4_spur_run", run, 0);

    // instruction counter saturation
    load4(9'h080, 9'h081, 9'h082, 9'h083);
    for (int i = 0; i < 300; i++) push(mem[i % 4], mem[i % 4], 4);
    pulse_start();
    serve(254);
    @(negedge clk);
    chk("cnt_254", instr_cnt, 254);
    serve(1);
    @(negedge clk);
    chk("cnt_255", instr_cnt, 255);
    serve(45);
    @(negedge clk);
    chk("cnt_sat", instr_cnt, 255);
    do_reset();

    // done never arrives
    load4(9'h008, 9'h1C0, 9'h000, 9'h000);
    push(9'h008, 9'h008, 4);
    pulse_start();
    wait_run(ok);
`ifdef WATCHDOG_EN
    repeat (14) @(negedge clk);
    chk("wd_run_before", run, 1);
    chk("wd_err_before", err, 0);
    @(negedge clk);
    chk("wd_err", err, 1);
    chk("wd_run", run, 0);
    chk("wd_halted", halted, 1);
    push(9'h008, 9'h008, 4);
    pulse_start();
    @(negedge clk);
    chk("wd_err_clr", err, 0);
    wait_run(ok);
    repeat (2) @(negedge clk);
    do_reset();
`else
    repeat (120) @(negedge clk);
    chk("nowd_run", run, 1);
    chk("nowd_err", err, 0);
    chk("nowd_busy", busy, 1);
    do_reset();
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
